i2c_target: RTL

Synchronous I2C target (slave) holding a 256×8 register file; it answers the board-level I2C initiator the same way the HDMI transmitter does, with 7-bit addressing and an 8-bit subaddress. It is used for two things: as a bench model of the HDMI transmitter for simulating the core's `i2c_master`, and to expose core configuration registers to an external I2C controller. SCL and SDA are sampled on `clk_sys` and never stretched; SDA is open-drain, driven low through `sda_oe`.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_filter.sv | 52 +++++
 rtl/i2c_target.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    DEVACK,
    SUBADDR,
    SUBACK,
    WDATA,
    WACK,
    RDATA,
    RACK
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_filter.sv
// Two-flop synchronizer plus glitch filter for one I2C line, with edge strobes
// that are aligned with the cycle the filtered value changes.
module i2c_filter #(
  parameter int FILTER = 3
) (
  input  logic clk_sys,
  input  logic res_n,
  input  logic line_raw,
  output logic filt,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [2:0] cnt;

  // metastability guard; idle bus level is high
  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= line_raw;
      sync2 <= sync1;
    end
  end

  // accept a new level only after FILTER consecutive differing samples
  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      filt <= 1'b1;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == 3'(FILTER - 1)) begin
        filt <= sync2;
        cnt  <= '0;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target with 8-bit subaddress into a 256x8 register file.
//   state   | meaning
//   IDLE    | not addressed, line released
//   DEVADDR | shifting in device address + R/W
//   DEVACK  | acknowledging device address
//   SUBADDR | shifting in register pointer
//   SUBACK  | acknowledging subaddress
//   WDATA   | shifting in write data
//   WACK    | acknowledging write data
//   RDATA   | driving read data MSB first
//   RACK    | line released, sampling initiator ACK/NACK
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         FILTER   = 3
) (
  input  logic       clk_sys,
  input  logic       res_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_filter #(.FILTER(FILTER)) u_scl_filt (
    .clk_sys (clk_sys), .res_n (res_n), .line_raw (scl_i),
    .filt    (scl),     .rise  (scl_rise), .fall  (scl_fall)
  );

  i2c_filter #(.FILTER(FILTER)) u_sda_filt (
    .clk_sys (clk_sys), .res_n (res_n), .line_raw (sda_i),
    .filt    (sda),     .rise  (sda_rise), .fall  (sda_fall)
  );

  i2c_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] ptr, ptr_n;
  logic       ph, ph_n;
  logic       sda_oe_n, busy_n;
  logic       wr_en;
  logic [7:0] rx_byte;
  logic [7:0] ram_q;
  logic [7:0] regs [256];

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign rx_byte   = {shreg[6:0], sda};

  // FSM state and datapath registers
  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      ph      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      ph      <= ph_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      wr_stb  <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  // next-state logic; ph marks the second half of an ACK slot
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    ph_n      = ph;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_en     = 1'b0;
    if (start_det) begin
      state_n   = DEVADDR;
      bit_cnt_n = '0;
      ph_n      = 1'b0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      ph_n      = 1'b0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        DEVADDR, SUBADDR, WDATA: begin
          if (scl_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == DEVADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_n = DEVACK;
                  busy_n  = 1'b1;
                end else begin
                  state_n = IDLE;
                end
              end else if (state == SUBADDR) begin
                ptr_n   = rx_byte;
                state_n = SUBACK;
              end else begin
                wr_en   = res_n;
                ptr_n   = ptr + 8'd1;
                state_n = WACK;
              end
            end
          end
        end
        DEVACK, SUBACK, WACK: begin
          if (scl_fall) begin
            if (!ph) begin
              ph_n     = 1'b1;
              sda_oe_n = ~ACK;
            end else begin
              ph_n     = 1'b0;
              sda_oe_n = 1'b0;
              // shreg[0] still holds R/W from the address byte
              if (state == DEVACK && shreg[0]) begin
                state_n   = RDATA;
                shreg_n   = ram_q;
                sda_oe_n  = ~ram_q[7];
                bit_cnt_n = '0;
              end else if (state == DEVACK) begin
                state_n = SUBADDR;
              end else begin
                state_n = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              state_n  = RACK;
              sda_oe_n = 1'b0;
              ph_n     = 1'b0;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise && !ph) begin
            if (sda == ACK) begin
              ptr_n = ptr + 8'd1;
              ph_n  = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else if (scl_fall && ph) begin
            // ram_q already reflects the incremented pointer
            state_n   = RDATA;
            ph_n      = 1'b0;
            shreg_n   = ram_q;
            sda_oe_n  = ~ram_q[7];
            bit_cnt_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // register file port A: bus write and read prefetch
  always_ff @(posedge clk_sys) begin
    if (wr_en) regs[ptr] <= rx_byte;
    ram_q <= regs[ptr];
  end

  // register file port B: host read, old data on a same-address collision
  always_ff @(posedge clk_sys) begin
    if (!res_n) host_data <= '0;
    else        host_data <= regs[host_addr];
  end

endmodule
